// File: rtl/stack_pkg.sv
// ---------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the lifo_stack_param stack.
//   OP_*        2-bit operation codes, formed as {push, pop}
//   cnt_width   width needed to hold an occupancy count of 0..depth
//   addr_width  width needed to address depth entries (depth >= 2)
// ---------------------------------------------------------------------------
package stack_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/lifo_stack_param_if.sv
// ---------------------------------------------------------------------------
// lifo_stack_param_if
// Bundles the request/response signals of the LIFO stack.
//   enable, push, pop, data_in        requester -> stack
//   data_out, count, empty, full      stack -> requester (state)
//   overflow, underflow               stack -> requester (1-cycle pulses)
//   wm_clr / max_count                watermark clear / peak occupancy,
//                                     present only with STACK_WATERMARK_EN
// Modports: master = requester side, slave = stack side.
// ---------------------------------------------------------------------------
interface lifo_stack_param_if
  import stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic             enable;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef STACK_WATERMARK_EN
  logic             wm_clr;
  logic [CNT_W-1:0] max_count;

  modport master (
    output enable, push, pop, data_in, wm_clr,
    input  data_out, count, empty, full, overflow, underflow, max_count
  );

  modport slave (
    input  enable, push, pop, data_in, wm_clr,
    output data_out, count, empty, full, overflow, underflow, max_count
  );
`else
  modport master (
    output enable, push, pop, data_in,
    input  data_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  enable, push, pop, data_in,
    output data_out, count, empty, full, overflow, underflow
  );
`endif

endinterface

// File: rtl/lifo_mem.sv
// ---------------------------------------------------------------------------
// lifo_mem
// WIDTH x DEPTH register file backing the stack: one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
//   clk    clock, rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module lifo_mem #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack_param.sv
// ---------------------------------------------------------------------------
// lifo_stack_param
// Parametrised LIFO stack with push, pop and same-cycle push+pop
// (replace top), occupancy count and one-cycle overflow/underflow pulses.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset (clears count, flags, watermark;
//         the memory contents are kept but become unreachable)
//   bus   lifo_stack_param_if.slave: enable/push/pop/data_in in,
//         data_out/count/empty/full/overflow/underflow out
// Optional build macro STACK_WATERMARK_EN adds bus.wm_clr and bus.max_count
// (peak occupancy since reset or last clear).
// ---------------------------------------------------------------------------
module lifo_stack_param
  import stack_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  lifo_stack_param_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int AW    = addr_width(DEPTH);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             overflow_reg;
  logic             overflow_next;
  logic             underflow_reg;
  logic             underflow_next;

  logic [1:0]       op;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] top_idx;
  logic [AW-1:0]    raddr;
  logic [AW-1:0]    waddr;
  logic             we;
  logic [WIDTH-1:0] rdata;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  // Only meaningful when not empty; the read result is masked otherwise.
  assign top_idx = count_reg - CNT_W'(1);
  assign raddr   = AW'(top_idx);

  // A disabled cycle is treated exactly like an idle request.
  assign op = bus.enable ? {bus.push, bus.pop} : OP_IDLE;

  always_comb begin
    count_next     = count_reg;
    we             = 1'b0;
    waddr          = raddr;
    overflow_next  = 1'b0;
    underflow_next = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          overflow_next = 1'b1;
        end else begin
          we         = 1'b1;
          waddr      = AW'(count_reg);
          count_next = count_reg + CNT_W'(1);
        end
      end
      OP_POP: begin
        if (empty) begin
          underflow_next = 1'b1;
        end else begin
          count_next = top_idx;
        end
      end
      OP_REPL: begin
        // Replace the top word; on an empty stack this degenerates to a push.
        we = 1'b1;
        if (empty) begin
          waddr      = '0;
          count_next = CNT_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  lifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.data_in),
    .raddr (raddr),
    .rdata (rdata)
  );

  assign bus.data_out  = empty ? '0 : rdata;
  assign bus.count     = count_reg;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;

`ifdef STACK_WATERMARK_EN
  logic [CNT_W-1:0] max_count_reg;

  // Tracks the post-edge occupancy so the peak matches what count will show.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_count_reg <= '0;
    end else if (bus.wm_clr) begin
      max_count_reg <= count_next;
    end else if (count_next > max_count_reg) begin
      max_count_reg <= count_next;
    end
  end

  assign bus.max_count = max_count_reg;
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack_param
// Table-driven bench for lifo_stack_param (WIDTH=4, DEPTH=8), plus
// hand-written sequences for asynchronous reset and the optional watermark.
// ---------------------------------------------------------------------------
module tb_lifo_stack_param;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  int checks;
  int errors;

  lifo_stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  lifo_stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   grp;
    logic en;
    logic push;
    logic pop;
    int   din;
    int   cnt;
    int   dout;
    logic ovf;
    logic udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int grp, input logic en, input logic pu, input logic po,
                     input int din, input int cnt, input int dout,
                     input logic ovf, input logic udf);
    vec_t v;
    v.grp = grp; v.en = en; v.push = pu; v.pop = po; v.din = din;
    v.cnt = cnt; v.dout = dout; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input int cnt, input int dout,
                           input int ovf, input int udf);
    chk({tag, " count"},     int'(bus.count),     cnt);
    chk({tag, " data_out"},  int'(bus.data_out),  dout);
    chk({tag, " empty"},     int'(bus.empty),     (cnt == 0) ? 1 : 0);
    chk({tag, " full"},      int'(bus.full),      (cnt == DEPTH) ? 1 : 0);
    chk({tag, " overflow"},  int'(bus.overflow),  ovf);
    chk({tag, " underflow"}, int'(bus.underflow), udf);
  endtask

  // Drive one request, let the edge perform it, then sample 1 time unit later.
  task automatic step(input logic en, input logic pu, input logic po, input int din);
    bus.enable  = en;
    bus.push    = pu;
    bus.pop     = po;
    bus.data_in = WIDTH'(din);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.enable  = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
`ifdef STACK_WATERMARK_EN
    bus.wm_clr  = 1'b0;
`endif

    // 1: idle after reset
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // 2: fill with 1..8, then overflow, then replace-top while full
    for (int k = 1; k <= DEPTH; k++) add(2, 1, 1, 0, k, k, k, 0, 0);
    add(2, 1, 1, 0, 15, 8, 8, 1, 0);
    add(2, 1, 0, 0, 0, 8, 8, 0, 0);
    add(2, 1, 1, 1, 14, 8, 14, 0, 0);
    // 3: drain, then underflow
    for (int k = 1; k <= DEPTH; k++) add(3, 1, 0, 1, 0, DEPTH - k, DEPTH - k, 0, 0);
    add(3, 1, 0, 1, 0, 0, 0, 0, 1);
    add(3, 1, 0, 0, 0, 0, 0, 0, 0);
    // 4: replace-top, pop, replace on empty
    add(4, 1, 1, 0, 3, 1, 3, 0, 0);
    add(4, 1, 1, 0, 5, 2, 5, 0, 0);
    add(4, 1, 1, 1, 9, 2, 9, 0, 0);
    add(4, 1, 0, 1, 0, 1, 3, 0, 0);
    add(4, 1, 0, 1, 0, 0, 0, 0, 0);
    add(4, 1, 1, 1, 10, 1, 10, 0, 0);
    add(4, 1, 0, 1, 0, 0, 0, 0, 0);
    // 5: push two words, then requests with enable low hold state
    add(5, 1, 1, 0, 6, 1, 6, 0, 0);
    add(5, 1, 1, 0, 7, 2, 7, 0, 0);
    for (int k = 0; k < 3; k++) add(5, 0, 1, 0, 15, 2, 7, 0, 0);
    add(5, 0, 1, 1, 12, 2, 7, 0, 0);

    // Reset state, checked before any clock edge has been seen
    #1;
    chk_state("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].din);
      $display("vec %0d grp %0d en=%0b push=%0b pop=%0b din=%0h -> count=%0d data_out=%0h ovf=%0b udf=%0b",
               i, vecs[i].grp, vecs[i].en, vecs[i].push, vecs[i].pop, vecs[i].din,
               bus.count, bus.data_out, bus.overflow, bus.underflow);
      chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].ovf, vecs[i].udf);
    end

    // 5b: asynchronous reset in the middle of a pending push
    bus.enable  = 1'b1;
    bus.push    = 1'b1;
    bus.pop     = 1'b0;
    bus.data_in = 4'h9;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset mid-push -> count=%0d empty=%0b", bus.count, bus.empty);
    chk_state("async_rst", 0, 0, 0, 0);
    bus.push = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0);
    $display("idle after reset release -> count=%0d", bus.count);
    chk_state("post_rst", 0, 0, 0, 0);

`ifdef STACK_WATERMARK_EN
    // 6: watermark follows the peak, wm_clr reloads it with the current count
    chk("wm reset", int'(bus.max_count), 0);
    for (int k = 1; k <= 5; k++) step(1, 1, 0, k);
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0);
    $display("wm after push5/pop3 -> count=%0d max_count=%0d", bus.count, bus.max_count);
    chk("wm count", int'(bus.count), 2);
    chk("wm peak", int'(bus.max_count), 5);
    bus.wm_clr = 1'b1;
    step(1, 0, 0, 0);
    bus.wm_clr = 1'b0;
    $display("wm after clear -> max_count=%0d", bus.max_count);
    chk("wm clear", int'(bus.max_count), 2);
    step(1, 1, 0, 7);
    $display("wm after push -> max_count=%0d", bus.max_count);
    chk("wm regrow", int'(bus.max_count), 3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
